sar_step_gen: RTL

//  Drives the 10-bit SAR in the FMDLL loop.

---
 rtl/fmdll_pkg.sv | 10 +
 rtl/pd_vote_acc.sv | 45 ++++
 rtl/sar_step_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared SAR sequencer types and defaults for the FMDLL loop
//   Contents: state_t (IDLE..DONE), SAR_NBITS, SAR_RST_CODE,
//   DEF_SETTLE_CYC, DEF_WIN
package fmdll_pkg;
    localparam int                   SAR_NBITS      = 10;
    localparam logic [SAR_NBITS-1:0] SAR_RST_CODE   = 10'b1000000000;
    localparam int                   DEF_SETTLE_CYC = 8;
    localparam int                   DEF_WIN        = 15;
    typedef enum logic [2:0] {IDLE, CLR, SETTLE, SAMPLE, DECIDE, DONE} state_t;
endpackage

// File: rtl/pd_vote_acc.sv
// pd_vote_acc: synchronises the PD lead bit and majority-votes it over a window
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_clr           : clears window and lead counters
//   i_en            : accumulate one synced sample per cycle
//   i_pd_lead       : raw async PD output
//   o_win_done      : high in the last enabled cycle of the window
//   o_lead_major    : vote result including the current sample
module pd_vote_acc #(
    parameter int WIN = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_pd_lead,
    output logic o_win_done,
    output logic o_lead_major
);
    localparam int CW = $clog2(WIN + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_win_cnt;
    logic [CW-1:0] r_lead_cnt;
    logic [CW-1:0] w_lead_nxt;
    // Saturating add; the last sample is folded in combinationally so the
    // decision can be registered in the same cycle the window closes.
    assign w_lead_nxt   = (r_lead_cnt == CW'(WIN)) ? r_lead_cnt : r_lead_cnt + CW'(r_sync[1]);
    assign o_win_done   = i_en && (r_win_cnt == CW'(WIN - 1));
    assign o_lead_major = w_lead_nxt > CW'(WIN / 2);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_win_cnt  <= '0;
            r_lead_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pd_lead};
            if (i_clr) begin
                r_win_cnt  <= '0;
                r_lead_cnt <= '0;
            end else if (i_en) begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_lead_cnt <= w_lead_nxt;
            end
        end
    end
endmodule

// File: rtl/sar_step_gen.sv
// sar_step_gen: SAR step sequencer for the FMDLL loop
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_start         : rising edge starts (or restarts) a conversion
//   i_pd_lead       : raw async PD lead bit
//   o_comp          : voted decision to SAR COMP (1 = lead)
//   o_step          : one-cycle SAR clock enable
//   o_sar_rst_n     : one-cycle active-low SAR re-init
//   o_busy, o_done  : conversion in progress / complete (sticky)
//   o_step_idx      : SAR bit currently being decided
//   Macro SAR_TRACK_EN: keep stepping the LSB after done to track drift.
module sar_step_gen import fmdll_pkg::*; #(
    parameter int NBITS      = SAR_NBITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WIN        = DEF_WIN
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pd_lead,
    output logic       o_comp,
    output logic       o_step,
    output logic       o_sar_rst_n,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_step_idx
);
`ifdef SAR_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif
    localparam int         SW      = $clog2(SETTLE_CYC + 1);
    localparam logic [3:0] IDX_TOP = 4'(NBITS - 1);
    state_t        r_state;
    logic          r_start_q;
    logic          r_start_qq;
    logic [SW-1:0] r_cnt;
    logic          w_start_edge;
    logic          w_win_done;
    logic          w_lead_major;
    assign w_start_edge = r_start_q & ~r_start_qq;
    pd_vote_acc #(.WIN(WIN)) u_vote (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (r_state == SETTLE),
        .i_en        (r_state == SAMPLE),
        .i_pd_lead   (i_pd_lead),
        .o_win_done  (w_win_done),
        .o_lead_major(w_lead_major)
    );
    // DECIDE spans two cycles: comp is already valid in the first, the step
    // strobe is raised in the second, so comp is stable before and during it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_start_qq  <= 1'b0;
            r_cnt       <= '0;
            o_comp      <= 1'b0;
            o_step      <= 1'b0;
            o_sar_rst_n <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_step_idx  <= IDX_TOP;
        end else begin
            r_start_q   <= i_start;
            r_start_qq  <= r_start_q;
            o_step      <= 1'b0;
            o_sar_rst_n <= 1'b1;
            if (w_start_edge) begin
                r_state     <= CLR;
                r_cnt       <= '0;
                o_sar_rst_n <= 1'b0;
                o_step_idx  <= IDX_TOP;
                o_done      <= 1'b0;
                o_busy      <= 1'b1;
            end else begin
                case (r_state)
                    CLR: r_state <= SETTLE;
                    SETTLE: begin
                        r_cnt   <= (r_cnt == SW'(SETTLE_CYC - 1)) ? '0 : r_cnt + 1'b1;
                        r_state <= (r_cnt == SW'(SETTLE_CYC - 1)) ? SAMPLE : SETTLE;
                    end
                    SAMPLE: if (w_win_done) begin
                        o_comp  <= w_lead_major;
                        r_state <= DECIDE;
                    end
                    DECIDE: if (!o_step) begin
                        o_step <= 1'b1;
                    end else if (o_step_idx == 4'd0) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= TRACK ? SETTLE : DONE;
                    end else begin
                        o_step_idx <= o_step_idx - 1'b1;
                        r_state    <= SETTLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
